// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared types and encodings for the RV32I multi-cycle control FSM
package ctrl_pkg;
    typedef enum logic [2:0] {S_RESET, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_ERROR} state_t;
    typedef enum logic [2:0] {C_OP, C_OPIMM, C_LOAD, C_STORE, C_BRANCH, C_LUI, C_JAL} iclass_t;
    typedef enum logic [1:0] {PC_PLUS4, PC_BRANCH, PC_JUMP} pc_src_t;
    typedef enum logic [1:0] {WB_ALU, WB_MEM, WB_PC4} wb_sel_t;
    typedef enum logic [1:0] {F_NONE, F_ILLEGAL, F_TIMEOUT} fault_t;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [3:0] ALU_ADD    = 4'b0000;
    localparam logic [3:0] ALU_SUB    = 4'b1000;
    localparam logic [3:0] ALU_PASSB  = 4'b1111;
endpackage

// File: rtl/instr_decoder.sv
// instr_decoder: combinational RV32I classifier producing class, legality and ALU controls
module instr_decoder
    import ctrl_pkg::*;
#(
    parameter bit SUPPORT_MEM = 1'b1
) (
    input  logic [31:0] instr,
    output iclass_t     cls,
    output logic        illegal,
    output logic [3:0]  alu_op,
    output logic        alu_src_imm
);
    logic [6:0] opc;
    logic [6:0] f7;
    logic [2:0] f3;
    logic       unused;
    assign opc    = instr[6:0];
    assign f3     = instr[14:12];
    assign f7     = instr[31:25];
    assign unused = ^{instr[24:15], instr[11:7]};
    always_comb begin
        cls         = C_OP;
        illegal     = 1'b0;
        alu_op      = ALU_ADD;
        alu_src_imm = 1'b0;
        case (opc)
            OPC_OP: begin
                illegal = !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101)));
                alu_op  = {f7[5], f3};
            end
            OPC_OPIMM: begin
                cls         = C_OPIMM;
                illegal     = (f3 == 3'b001 && f7 != 7'h00) || (f3 == 3'b101 && f7 != 7'h00 && f7 != 7'h20);
                alu_op      = {f3 == 3'b101 && f7[5], f3};
                alu_src_imm = 1'b1;
            end
            OPC_LOAD: begin
                cls         = C_LOAD;
                illegal     = !SUPPORT_MEM;
                alu_src_imm = 1'b1;
            end
            OPC_STORE: begin
                cls         = C_STORE;
                illegal     = !SUPPORT_MEM;
                alu_src_imm = 1'b1;
            end
            OPC_BRANCH: begin
                cls    = C_BRANCH;
                alu_op = ALU_SUB;
            end
            OPC_LUI: begin
                cls         = C_LUI;
                alu_op      = ALU_PASSB;
                alu_src_imm = 1'b1;
            end
            OPC_JAL: cls = C_JAL;
            default: illegal = 1'b1;
        endcase
    end
endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: RV32I multi-cycle sequencer with memory req/ack timeout and sticky fault
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter bit SUPPORT_MEM = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic        mem_ack,
    input  logic        branch_taken,
    output logic        mem_req,
    output logic        mem_we,
    output logic        ir_load,
    output logic        alubuf1_load,
    output logic        alubuf2_load,
    output logic        alu_src_imm,
    output logic [3:0]  alu_op,
    output logic        rf_write,
    output logic [1:0]  wb_sel,
    output logic        pc_load,
    output logic [1:0]  pc_src,
    output logic        instr_retired,
    output logic [1:0]  fault,
    output logic        halted
);
    localparam int            CW   = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] LAST = CW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);
    state_t        state;
    fault_t        fault_r;
    logic [CW-1:0] wait_cnt;
    iclass_t       cls;
    logic          illegal;
    logic          dec_imm;
    logic [3:0]    dec_op;
    logic          req_wait;
    logic          timed_out;
    logic          in_fetch, in_dec, in_exec, in_mem, in_wb;
    logic          br_done, st_done;
    instr_decoder #(.SUPPORT_MEM(SUPPORT_MEM)) u_dec (
        .instr       (instr),
        .cls         (cls),
        .illegal     (illegal),
        .alu_op      (dec_op),
        .alu_src_imm (dec_imm)
    );
    // an ack in the final allowed request cycle beats the timeout
    assign req_wait  = (state == S_FETCH || state == S_MEM) && !mem_ack;
    assign timed_out = (MEM_TIMEOUT > 0) && req_wait && wait_cnt == LAST;
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= S_RESET;
            fault_r  <= F_NONE;
            wait_cnt <= '0;
        end else begin
            wait_cnt <= (req_wait && MEM_TIMEOUT > 0) ? wait_cnt + 1'b1 : '0;
            if (timed_out) begin
                state   <= S_ERROR;
                fault_r <= F_TIMEOUT;
            end else begin
                case (state)
                    S_RESET:  state <= S_FETCH;
                    S_FETCH:  state <= mem_ack ? S_DECODE : S_FETCH;
                    S_DECODE: begin
                        state <= illegal ? S_ERROR : S_EXEC;
                        if (illegal) fault_r <= F_ILLEGAL;
                    end
                    S_EXEC:   state <= (cls == C_BRANCH) ? S_FETCH :
                                       (cls == C_LOAD || cls == C_STORE) ? S_MEM : S_WB;
                    S_MEM:    state <= !mem_ack ? S_MEM : (cls == C_STORE) ? S_FETCH : S_WB;
                    S_WB:     state <= S_FETCH;
                    S_ERROR:  state <= S_ERROR;
                    default:  state <= S_ERROR;
                endcase
            end
        end
    end
    assign in_fetch      = state == S_FETCH;
    assign in_dec        = state == S_DECODE;
    assign in_exec       = state == S_EXEC;
    assign in_mem        = state == S_MEM;
    assign in_wb         = state == S_WB;
    assign br_done       = in_exec && cls == C_BRANCH;
    assign st_done       = in_mem && cls == C_STORE && mem_ack;
    assign mem_req       = in_fetch || in_mem;
    assign mem_we        = in_mem && cls == C_STORE;
    assign ir_load       = in_fetch && mem_ack;
    assign alubuf1_load  = in_dec;
    assign alubuf2_load  = in_dec;
    assign alu_src_imm   = in_exec && dec_imm;
    assign alu_op        = in_exec ? dec_op : ALU_ADD;
    assign rf_write      = in_wb && instr[11:7] != 5'd0;
    assign wb_sel        = !in_wb ? WB_ALU : (cls == C_LOAD) ? WB_MEM : (cls == C_JAL) ? WB_PC4 : WB_ALU;
    assign pc_load       = br_done || st_done || in_wb;
    assign pc_src        = (br_done && branch_taken) ? PC_BRANCH : (in_wb && cls == C_JAL) ? PC_JUMP : PC_PLUS4;
    assign instr_retired = pc_load;
    assign fault         = fault_r;
    assign halted        = state == S_ERROR;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed self-checking bench for multicycle_ctrl (MEM_TIMEOUT=4)
module tb_multicycle_ctrl;
    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] instr;
    logic        mem_ack;
    logic        branch_taken;
    logic        mem_req, mem_we, ir_load, alubuf1_load, alubuf2_load, alu_src_imm;
    logic [3:0]  alu_op;
    logic        rf_write;
    logic [1:0]  wb_sel;
    logic        pc_load;
    logic [1:0]  pc_src;
    logic        instr_retired;
    logic [1:0]  fault;
    logic        halted;
    int          errors = 0;
    int          checks = 0;

    multicycle_ctrl #(.MEM_TIMEOUT(4), .SUPPORT_MEM(1'b1)) dut (
        .clock         (clock),
        .reset         (reset),
        .instr         (instr),
        .mem_ack       (mem_ack),
        .branch_taken  (branch_taken),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .ir_load       (ir_load),
        .alubuf1_load  (alubuf1_load),
        .alubuf2_load  (alubuf2_load),
        .alu_src_imm   (alu_src_imm),
        .alu_op        (alu_op),
        .rf_write      (rf_write),
        .wb_sel        (wb_sel),
        .pc_load       (pc_load),
        .pc_src        (pc_src),
        .instr_retired (instr_retired),
        .fault         (fault),
        .halted        (halted)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // pulse reset from a clock-aligned point and return in FETCH
    task automatic reset_pulse(input string tag);
        reset = 1'b0;
        #1;
        check({tag, "_fault_clr"}, 32'(fault), 0);
        check({tag, "_halt_clr"}, 32'(halted), 0);
        tick();
        reset = 1'b1;
        mem_ack = 1'b0;
        tick();
        check({tag, "_fetch"}, 32'(mem_req), 1);
    endtask

    // non-memory, non-branch instruction: FETCH, DECODE, EXEC, WB
    task automatic run_alu(input string tag, input logic [31:0] w, input int op, input int imm,
                           input int ws, input int rfw, input int ps);
        int n;
        instr = w;
        mem_ack = 1'b1;
        #1;
        check({tag, "_irl"}, 32'(ir_load), 1);
        tick();
        mem_ack = 1'b0;
        #1;
        check({tag, "_bufs"}, 32'({alubuf1_load, alubuf2_load}), 3);
        tick();
        check({tag, "_aluop"}, 32'(alu_op), op);
        check({tag, "_imm"}, 32'(alu_src_imm), imm);
        n = 3;
        while (!instr_retired && n < 10) begin
            tick();
            n++;
        end
        check({tag, "_ret_cyc"}, n, 4);
        check({tag, "_wbsel"}, 32'(wb_sel), ws);
        check({tag, "_rfw"}, 32'(rf_write), rfw);
        check({tag, "_pcld"}, 32'(pc_load), 1);
        check({tag, "_pcsrc"}, 32'(pc_src), ps);
        tick();
        check({tag, "_next_fetch"}, 32'(mem_req), 1);
    endtask

    task automatic run_branch(input string tag, input logic taken);
        instr = 32'h00208463;
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        tick();
        branch_taken = taken;
        #1;
        check({tag, "_aluop"}, 32'(alu_op), 4'b1000);
        check({tag, "_pcld"}, 32'(pc_load), 1);
        check({tag, "_pcsrc"}, 32'(pc_src), 32'(taken));
        check({tag, "_ret"}, 32'(instr_retired), 1);
        tick();
        branch_taken = 1'b0;
        check({tag, "_no_wb"}, 32'({mem_req, rf_write, instr_retired}), 3'b100);
    endtask

    initial begin
        reset = 1'b0;
        mem_ack = 1'b0;
        branch_taken = 1'b0;
        instr = 32'h0;
        #3;
        mem_ack = 1'b1;
        #1;
        check("rst_req", 32'(mem_req), 0);
        check("rst_irl", 32'(ir_load), 0);
        check("rst_fault", 32'(fault), 0);
        check("rst_halt", 32'(halted), 0);
        mem_ack = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        #1;
        check("reset_state_req", 32'(mem_req), 0);
        tick();
        check("first_fetch_req", 32'(mem_req), 1);
        check("first_fetch_we", 32'(mem_we), 0);

        run_alu("add",      32'h002081B3, 4'b0000, 0, 0, 1, 0);
        run_alu("sub_x0",   32'h40208033, 4'b1000, 0, 0, 0, 0);
        run_alu("srai",     32'h4020D093, 4'b1101, 1, 0, 1, 0);
        run_alu("addi_neg", 32'hFFF00093, 4'b0000, 1, 0, 1, 0);
        run_alu("lui",      32'h123450B7, 4'b1111, 1, 0, 1, 0);
        run_alu("jal",      32'h008000EF, 4'b0000, 0, 2, 1, 2);
        run_branch("beq_t", 1'b1);
        run_branch("beq_nt", 1'b0);

        // LW x5,4(x1) with ack on the 4th MEM cycle (also the last one before timeout)
        instr = 32'h0040A283;
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        tick();
        check("lw_aluop", 32'(alu_op), 0);
        check("lw_imm", 32'(alu_src_imm), 1);
        tick();
        for (int i = 0; i < 4; i++) begin
            mem_ack = (i == 3);
            #1;
            check("lw_mem_req", 32'({mem_req, mem_we, pc_load}), 3'b100);
            if (i < 3) tick();
        end
        tick();
        mem_ack = 1'b0;
        check("lw_wbsel", 32'(wb_sel), 1);
        check("lw_rfw", 32'(rf_write), 1);
        check("lw_ret", 32'(instr_retired), 1);
        tick();
        check("lw_next_fetch", 32'(mem_req), 1);

        // SW x2,8(x1), ack immediately in MEM
        instr = 32'h0020A423;
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        tick();
        check("sw_imm", 32'(alu_src_imm), 1);
        tick();
        check("sw_req_we", 32'({mem_req, mem_we, instr_retired}), 3'b110);
        mem_ack = 1'b1;
        #1;
        check("sw_done", 32'({pc_load, pc_src, instr_retired, rf_write}), 5'b10010);
        tick();
        mem_ack = 1'b0;
        #1;
        check("sw_next_fetch", 32'({mem_req, mem_we}), 2'b10);

        // SRA with funct3=010 is illegal
        instr = 32'h4020A033;
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        tick();
        check("ill_fault", 32'(fault), 1);
        check("ill_halt", 32'(halted), 1);
        check("ill_req", 32'(mem_req), 0);
        mem_ack = 1'b1;
        tick();
        check("ill_sticky", 32'({halted, fault, ir_load}), 4'b1010);
        mem_ack = 1'b0;
        reset_pulse("ill_rst");

        // no ack in FETCH: ERROR after 4 request cycles
        for (int i = 0; i < 4; i++) begin
            check("to_waiting", 32'({mem_req, halted}), 2'b10);
            tick();
        end
        check("to_halt", 32'(halted), 1);
        check("to_fault", 32'(fault), 2);
        check("to_req", 32'(mem_req), 0);
        reset_pulse("to_rst");

        // ack on the 4th request cycle wins over the timeout
        tick();
        tick();
        tick();
        instr = 32'h002081B3;
        mem_ack = 1'b1;
        #1;
        check("ack4_irl", 32'(ir_load), 1);
        tick();
        mem_ack = 1'b0;
        #1;
        check("ack4_decode", 32'({alubuf1_load, halted, mem_req}), 3'b100);
        check("ack4_fault", 32'(fault), 0);
        tick();
        tick();
        tick();

        // reset pulled during MEM of a store
        instr = 32'h0020A423;
        check("swr_fetch", 32'(mem_req), 1);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        tick();
        tick();
        check("swr_mem", 32'({mem_req, mem_we}), 2'b11);
        mem_ack = 1'b1;
        reset = 1'b0;
        #1;
        check("swr_async", 32'({mem_req, mem_we, pc_load, instr_retired, rf_write}), 0);
        tick();
        mem_ack = 1'b0;
        reset = 1'b1;
        #1;
        check("swr_in_reset", 32'(mem_req), 0);
        tick();
        check("swr_resume", 32'({mem_req, mem_we}), 2'b10);
        check("swr_fault", 32'(fault), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not complete within time limit");
        $fatal(1, "watchdog");
    end
endmodule
